// File: rtl/spdif_pkg.sv
// Shared constants, FSM state type and preamble helper for the S/PDIF frame encoder.
// The preamble patterns are written for a preceding line level of 0.
package spdif_pkg;

    localparam logic [7:0] PRE_B = 8'hE8;
    localparam logic [7:0] PRE_M = 8'hE2;
    localparam logic [7:0] PRE_W = 8'hE4;

    localparam int SLOTS_PER_SUBFRAME = 32;
    localparam int FRAMES_PER_BLOCK   = 192;
    localparam int AUDIO_W            = 24;

    localparam int UIS_PER_SLOT = 2;
    localparam int PRE_UIS      = 4 * UIS_PER_SLOT;
    localparam int DATA_UIS     = AUDIO_W * UIS_PER_SLOT;
    localparam int TRAILER_UIS  = 4 * UIS_PER_SLOT;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_TRAILER
    } spdif_state_e;

    // B opens a block, M opens every other frame, W always opens the right subframe.
    function automatic logic [7:0] preamble_pattern(input logic right_sub, input logic block_first);
        logic [7:0] pat;
        if (right_sub)
            pat = PRE_W;
        else if (block_first)
            pat = PRE_B;
        else
            pat = PRE_M;
        return pat;
    endfunction

endpackage

// File: rtl/spdif_bmc_serializer.sv
// Biphase-mark line driver: advances the line level once per UI tick, from either a
// preamble pattern (inverted when the preceding level was 1) or a slot data bit.
module spdif_bmc_serializer (
    input  logic clk,
    input  logic reset,
    input  logic ui_tick,
    input  logic pre_en,
    input  logic pre_first,
    input  logic pre_bit,
    input  logic slot_half,
    input  logic slot_bit,
    output logic spdif_out
);

    logic level_q;
    logic pre_inv_q;
    logic pre_inv;
    logic level_d;

    always_comb begin
        pre_inv = pre_first ? level_q : pre_inv_q;
        level_d = level_q;
        if (pre_en)
            level_d = pre_bit ^ pre_inv;
        else if (!slot_half)
            level_d = ~level_q;
        else
            level_d = level_q ^ slot_bit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q   <= 1'b0;
            pre_inv_q <= 1'b0;
        end else if (ui_tick) begin
            level_q <= level_d;
            if (pre_en && pre_first)
                pre_inv_q <= level_q;
        end
    end

    assign spdif_out = level_q;

endmodule

// File: rtl/spdif_frame_encoder.sv
// IEC 60958 consumer frame assembler and BMC encoder fed by a one-entry sample holding register.
// frame_start/block_start/underrun are asserted in the cycle whose UI tick launches the B/M preamble.
module spdif_frame_encoder
    import spdif_pkg::*;
#(
    parameter int         UI_DIV  = 4,
    parameter logic [3:0] CS_FS   = 4'b0010,
    parameter logic       CS_COPY = 1'b1
) (
    input  logic                pin_i2s_bclk_pll,
    input  logic                reset,
    input  logic [AUDIO_W-1:0]  s_left,
    input  logic [AUDIO_W-1:0]  s_right,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                spdif_out,
    output logic                frame_start,
    output logic                block_start,
    output logic                underrun
);

    localparam int              CNT_W   = (UI_DIV > 1) ? $clog2(UI_DIV) : 1;
    localparam logic [CNT_W-1:0] UI_LAST = CNT_W'(UI_DIV - 1);

    logic clk;
    assign clk = pin_i2s_bclk_pll;

    logic             run_q;
    logic [CNT_W-1:0] ui_cnt_q;
    logic             ui_tick;

    spdif_state_e state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic         sub_q, sub_d;
    logic [7:0]   frame_q, frame_d;
    logic         frame_load;

    logic                       full_q, full_d;
    logic                       xfer;
    logic signed [AUDIO_W-1:0]  hold_left, hold_right;
    logic signed [AUDIO_W-1:0]  tx_left, tx_right;
    logic                       tx_v;

    logic signed [AUDIO_W-1:0]  sub_audio;
    logic                       cs_now;
    logic                       parity;
    logic [7:0]                 pre_pat;
    logic                       pre_en, pre_first, pre_bit;
    logic                       slot_half, slot_bit;

    function automatic logic cs_bit(input logic [7:0] idx);
        logic b;
        b = 1'b0;
        if (idx == 8'd2)
            b = CS_COPY;
        else if (idx >= 8'd24 && idx <= 8'd27)
            b = CS_FS[idx[1:0]];
        return b;
    endfunction

    // UI timebase; run_q holds the counter for the first cycle out of reset
    assign ui_tick = run_q && (ui_cnt_q == UI_LAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sub_d      = sub_q;
        frame_d    = frame_q;
        frame_load = 1'b0;
        if (ui_tick) begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_PREAMBLE;
                    idx_d      = '0;
                    sub_d      = 1'b0;
                    frame_d    = '0;
                    frame_load = 1'b1;
                end
                ST_PREAMBLE: begin
                    if (idx_q == 6'(PRE_UIS - 1)) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (idx_q == 6'(DATA_UIS - 1)) begin
                        state_d = ST_TRAILER;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_TRAILER: begin
                    if (idx_q == 6'(TRAILER_UIS - 1)) begin
                        state_d = ST_PREAMBLE;
                        idx_d   = '0;
                        if (!sub_q) begin
                            sub_d = 1'b1;
                        end else begin
                            sub_d      = 1'b0;
                            frame_load = 1'b1;
                            frame_d    = (frame_q == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_q + 8'd1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A pair arriving on a frame-start edge stays buffered for the following frame
    assign s_ready = !full_q;
    assign xfer    = s_valid && s_ready;

    always_comb begin
        if (frame_load)
            full_d = xfer;
        else
            full_d = full_q | xfer;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q    <= 1'b0;
            ui_cnt_q <= '0;
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            sub_q    <= 1'b0;
            frame_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (run_q)
                ui_cnt_q <= ui_tick ? '0 : ui_cnt_q + 1'b1;
            state_q <= state_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            frame_q <= frame_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            hold_left  <= s_left;
            hold_right <= s_right;
        end
        if (frame_load) begin
            tx_left  <= full_q ? hold_left : '0;
            tx_right <= full_q ? hold_right : '0;
            tx_v     <= !full_q;
        end
    end

    // Slot content for the UI about to be launched on this tick
    always_comb begin
        sub_audio = sub_d ? tx_right : tx_left;
        cs_now    = cs_bit(frame_d);
        parity    = (^sub_audio) ^ tx_v ^ cs_now;
        pre_pat   = preamble_pattern(sub_d, frame_d == 8'd0);
        pre_en    = (state_d == ST_PREAMBLE);
        pre_first = (idx_d == 6'd0);
        pre_bit   = pre_pat[~idx_d[2:0]];
        slot_half = idx_d[0];
        slot_bit  = 1'b0;
        if (state_d == ST_DATA) begin
            slot_bit = sub_audio[idx_d[5:1]];
        end else begin
            case (idx_d[2:1])
                2'd0:    slot_bit = tx_v;
                2'd1:    slot_bit = 1'b0;
                2'd2:    slot_bit = cs_now;
                default: slot_bit = parity;
            endcase
        end
    end

    spdif_bmc_serializer u_bmc (
        .clk       (clk),
        .reset     (reset),
        .ui_tick   (ui_tick),
        .pre_en    (pre_en),
        .pre_first (pre_first),
        .pre_bit   (pre_bit),
        .slot_half (slot_half),
        .slot_bit  (slot_bit),
        .spdif_out (spdif_out)
    );

    assign frame_start = frame_load;
    assign block_start = frame_load && (frame_d == 8'd0);
    assign underrun    = frame_load && !full_q;

endmodule

// File: tb/tb_spdif_frame_encoder.sv
// Directed bench for spdif_frame_encoder at UI_DIV=1: records one UI per cycle for each
// frame and decodes preambles and BMC slots against hand-computed expectations.
module tb_spdif_frame_encoder;

    localparam logic [7:0] EXP_B = 8'b11101000;
    localparam logic [7:0] EXP_M = 8'b11100010;
    localparam logic [7:0] EXP_W = 8'b11100100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] s_left = '0;
    logic [23:0] s_right = '0;
    logic        s_valid = 1'b0;
    logic        s_ready, spdif_out, frame_start, block_start, underrun;

    always #5 clk = ~clk;

    spdif_frame_encoder #(.UI_DIV(1), .CS_FS(4'b0010), .CS_COPY(1'b1)) dut (
        .pin_i2s_bclk_pll (clk),
        .reset            (reset),
        .s_left           (s_left),
        .s_right          (s_right),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .spdif_out        (spdif_out),
        .frame_start      (frame_start),
        .block_start      (block_start),
        .underrun         (underrun)
    );

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        pl;
        logic        pr;
    } vec_t;

    vec_t tbl [6];

    int n_checks = 0;
    int n_pass = 0;
    int cur_frame = 0;

    logic [127:0] uis;
    logic         cap_bs, cap_ur, cap_rdy_fs, cap_rdy1;
    int           cap_rdy_low;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s (frame %0d): got %0h, expected %0h", name, cur_frame, act, exp);
    endtask

    function automatic logic [7:0] pre_of(input logic [127:0] u, input int base);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[7-j] = u[base+j];
        return r;
    endfunction

    function automatic logic [31:0] bits_of(input logic [127:0] u, input int base);
        logic [31:0] r;
        r = '0;
        for (int s = 4; s < 32; s++) r[s] = u[base+2*s] ^ u[base+2*s+1];
        return r;
    endfunction

    function automatic logic bmc_ok(input logic [127:0] u);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int s = 4; s < 32; s++)
                if (u[b*64+2*s] == u[b*64+2*s-1]) ok = 1'b0;
        return ok;
    endfunction

    // Waits (bounded) for frame_start at a falling edge, then records the 128 UIs of the frame.
    task automatic capture();
        int w;
        w = 0;
        while (!frame_start && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!frame_start) begin
            check("frame_start_timeout", 32'(frame_start), 32'd1);
            uis = '0;
            return;
        end
        cap_bs      = block_start;
        cap_ur      = underrun;
        cap_rdy_fs  = s_ready;
        cap_rdy_low = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (i == 0) cap_rdy1 = s_ready;
            if (!s_ready) cap_rdy_low++;
            uis[i] = spdif_out;
        end
    endtask

    task automatic check_frame(input logic [7:0] epre, input logic [23:0] el, input logic [23:0] er,
                               input logic ev, input logic ec, input logic epl, input logic epr);
        logic [31:0] bl, br;
        bl = bits_of(uis, 0);
        br = bits_of(uis, 64);
        check("pre_left",    32'(pre_of(uis, 0)),  32'(epre));
        check("pre_right",   32'(pre_of(uis, 64)), 32'(EXP_W));
        check("audio_left",  32'(bl[27:4]), 32'(el));
        check("audio_right", 32'(br[27:4]), 32'(er));
        check("v_left",      32'(bl[28]), 32'(ev));
        check("v_right",     32'(br[28]), 32'(ev));
        check("u_bits",      32'({bl[29], br[29]}), 32'd0);
        check("c_left",      32'(bl[30]), 32'(ec));
        check("c_right",     32'(br[30]), 32'(ec));
        check("p_left",      32'(bl[31]), 32'(epl));
        check("p_right",     32'(br[31]), 32'(epr));
        check("bmc_toggles", 32'(bmc_ok(uis)), 32'd1);
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r);
        int w;
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        w = 0;
        while (!s_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("send_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [23:0] el, er;
        logic        epl, epr, ec;
        int          w;

        tbl[0] = '{24'h000000, 24'hFFFFFF, 1'b0, 1'b0};
        tbl[1] = '{24'h000003, 24'h000007, 1'b0, 1'b1};
        tbl[2] = '{24'hA5A5A5, 24'h7FFFFF, 1'b0, 1'b1};
        tbl[3] = '{24'h800001, 24'h123456, 1'b0, 1'b1};
        tbl[4] = '{24'hFFFFFE, 24'h000100, 1'b1, 1'b1};
        tbl[5] = '{24'h5A5A5B, 24'hC00000, 1'b1, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_spdif_out",   32'(spdif_out),   32'd0);
        check("rst_s_ready",     32'(s_ready),     32'd1);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_block_start", 32'(block_start), 32'd0);
        check("rst_underrun",    32'(underrun),    32'd0);

        // continuous stream: frames 0..192, table vectors carried by frames 4..9
        s_left  = 24'h000001;
        s_right = 24'h800000;
        s_valid = 1'b1;
        reset   = 1'b0;
        for (int f = 0; f <= 192; f++) begin
            cur_frame = f;
            if (f >= 3 && f <= 8) begin
                s_left  = tbl[f-3].l;
                s_right = tbl[f-3].r;
            end
            capture();
            if (f <= 3) begin
                el = 24'h000001; er = 24'h800000; epl = 1'b1; epr = 1'b1;
            end else if (f <= 9) begin
                el = tbl[f-4].l; er = tbl[f-4].r; epl = tbl[f-4].pl; epr = tbl[f-4].pr;
            end else begin
                el = tbl[5].l; er = tbl[5].r; epl = tbl[5].pl; epr = tbl[5].pr;
            end
            ec = (f == 2 || f == 25);
            check("block_start", 32'(cap_bs), 32'(f == 0 || f == 192));
            check("underrun",    32'(cap_ur), 32'd0);
            check_frame((f == 0 || f == 192) ? EXP_B : EXP_M, el, er, 1'b0, ec, epl ^ ec, epr ^ ec);
        end

        // s_valid low from reset: every frame underruns
        reset = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cur_frame = k;
            capture();
            ec = (k == 2);
            check("ur_pulse",       32'(cap_ur), 32'd1);
            check("ur_block_start", 32'(cap_bs), 32'(k == 0));
            check("ur_ready_low",   32'(cap_rdy_low), 32'd0);
            check_frame(k == 0 ? EXP_B : EXP_M, 24'h0, 24'h0, 1'b1, ec, 1'b1 ^ ec, 1'b1 ^ ec);
        end

        // backpressure: A arrives on an underrun frame start, B is offered while the register is full
        fork
            begin
                send(24'h000001, 24'h000002);
                check("ready_drop_after_a", 32'(s_ready), 32'd0);
                send(24'h00000F, 24'h0000FF);
                send(24'h100000, 24'h300000);
                s_valid = 1'b0;
            end
            begin
                for (int k = 3; k <= 7; k++) begin
                    cur_frame = k;
                    capture();
                    if (k >= 4 && k <= 6) begin
                        check("bp_ready_at_fs",    32'(cap_rdy_fs), 32'd0);
                        check("bp_ready_after_fs", 32'(cap_rdy1),   32'd1);
                    end
                    check("bp_underrun", 32'(cap_ur), 32'(k == 3 || k == 7));
                    case (k)
                        4:       check_frame(EXP_M, 24'h000001, 24'h000002, 1'b0, 1'b0, 1'b1, 1'b1);
                        5:       check_frame(EXP_M, 24'h00000F, 24'h0000FF, 1'b0, 1'b0, 1'b0, 1'b0);
                        6:       check_frame(EXP_M, 24'h100000, 24'h300000, 1'b0, 1'b0, 1'b1, 1'b0);
                        default: check_frame(EXP_M, 24'h0, 24'h0, 1'b1, 1'b0, 1'b1, 1'b1);
                    endcase
                end
            end
        join

        // reset in the middle of right-subframe audio with a pair buffered
        cur_frame = 8;
        s_left  = 24'h00ABCD;
        s_right = 24'h00DCBA;
        s_valid = 1'b1;
        repeat (82) @(negedge clk);
        w = 0;
        while (!spdif_out && w < 8) begin
            @(negedge clk);
            w++;
        end
        check("pre_reset_line_high", 32'(spdif_out), 32'd1);
        check("pre_reset_full",      32'(s_ready),   32'd0);
        reset = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_spdif_out",   32'(spdif_out),   32'd0);
        check("mid_rst_s_ready",     32'(s_ready),     32'd1);
        check("mid_rst_frame_start", 32'(frame_start), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cur_frame = k;
            capture();
            ec = (k == 2);
            check("restart_block_start", 32'(cap_bs), 32'(k == 0));
            check("restart_underrun",    32'(cap_ur), 32'd1);
            check_frame(k == 0 ? EXP_B : EXP_M, 24'h0, 24'h0, 1'b1, ec, 1'b1 ^ ec, 1'b1 ^ ec);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
